// File: rtl/tetris_cell_blitter.sv
// Cell-granular framebuffer blitter: FILL paints a CELL x CELL square, COPY moves one.
// Acts as an Avalon-MM master on a single-port 16-bit RAM with one-cycle read latency.
module tetris_cell_blitter #(
  parameter int unsigned FB_WIDTH  = 320,
  parameter int unsigned FB_HEIGHT = 240,
  parameter int unsigned CELL      = 10,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned FB_BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_src_x,
  input  logic [7:0]        cmd_src_y,
  input  logic [15:0]       cmd_color,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [15:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CntW-1:0]   LastIdx = CntW'(CELL - 1);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(FB_WIDTH - CELL + 1);

  typedef enum logic [2:0] {StIdle, StFill, StCRead, StCWrite, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_dst_addr, r_src_addr;
  logic [CntW-1:0]   r_col, r_row;
  logic [15:0]       r_color;
  logic              r_err;

  logic              w_accept, w_bad, w_last, w_step;
  logic [ADDR_W-1:0] w_dst_start, w_src_start;

  assign cmd_ready = (r_state == StIdle) || (r_state == StDone);
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_bad = (32'(cmd_x) + CELL > FB_WIDTH) || (32'(cmd_y) + CELL > FB_HEIGHT) ||
                 (cmd_op && ((32'(cmd_src_x) + CELL > FB_WIDTH) ||
                             (32'(cmd_src_y) + CELL > FB_HEIGHT)));

  // Start addresses only; constant-width products reduce to shift-add, per-pixel stepping is additive.
  assign w_dst_start = ADDR_W'(FB_BASE) + ADDR_W'(cmd_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(cmd_x);
  assign w_src_start = ADDR_W'(FB_BASE) + ADDR_W'(cmd_src_y) * ADDR_W'(FB_WIDTH)
                       + ADDR_W'(cmd_src_x);

  assign w_last = (r_col == LastIdx) && (r_row == LastIdx);
  // A pixel retires only on a granted write.
  assign w_step = mem_grant && ((r_state == StFill) || (r_state == StCWrite));

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle, StDone: begin
        w_state_d = StIdle;
        if (w_accept && !w_bad) w_state_d = cmd_op ? StCRead : StFill;
      end
      StFill:   if (mem_grant && w_last) w_state_d = StDone;
      StCRead:  if (mem_grant) w_state_d = StCWrite;
      StCWrite: begin
        // Without grant the read data is stale, so re-read the same pixel.
        if (mem_grant && w_last) w_state_d = StDone;
        else                     w_state_d = StCRead;
      end
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    case (r_state)
      StFill: begin
        mem_address    = r_dst_addr;
        mem_chipselect = mem_grant;
        mem_write      = mem_grant;
        mem_writedata  = r_color;
      end
      StCRead: begin
        mem_address    = r_src_addr;
        mem_chipselect = mem_grant;
      end
      StCWrite: begin
        mem_address    = r_dst_addr;
        mem_chipselect = mem_grant;
        mem_write      = mem_grant;
        mem_writedata  = mem_readdata;
      end
      default: ;
    endcase
  end

  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;
  assign busy = (r_state == StFill) || (r_state == StCRead) || (r_state == StCWrite);
  assign done = (r_state == StDone);
  assign err  = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_err      <= 1'b0;
      r_dst_addr <= '0;
      r_src_addr <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_color    <= '0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        r_dst_addr <= w_dst_start;
        r_src_addr <= w_src_start;
        r_col      <= '0;
        r_row      <= '0;
        r_color    <= cmd_color;
      end else if (w_step) begin
        if (r_col == LastIdx) begin
          r_col      <= '0;
          r_row      <= r_row + CntW'(1);
          r_dst_addr <= r_dst_addr + RowStep;
          r_src_addr <= r_src_addr + RowStep;
        end else begin
          r_col      <= r_col + CntW'(1);
          r_dst_addr <= r_dst_addr + ADDR_W'(1);
          r_src_addr <= r_src_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tetris_cell_blitter.sv
// Bench for tetris_cell_blitter: RAM model, access monitor, table vectors, directed corner
// sequences and random commands checked against a pixel-level reference model.
module tb_tetris_cell_blitter;
  localparam int W = 320, H = 240, C = 10, NPIX = C * C, FBW = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, cmd_ready, cmd_op;
  logic [8:0]  cmd_x, cmd_src_x;
  logic [7:0]  cmd_y, cmd_src_y;
  logic [15:0] cmd_color;
  logic        mem_grant, man_grant, rand_mode, rnd_g;
  logic [16:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [15:0] mem_writedata, mem_readdata;
  logic        busy, done, err;

  tetris_cell_blitter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y),
    .cmd_color(cmd_color), .mem_grant(mem_grant), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .busy(busy), .done(done), .err(err)
  );

  assign mem_grant = rand_mode ? rnd_g : man_grant;
  always @(posedge clk) rnd_g <= ($urandom_range(3) != 0);

  // RAM model with a one-cycle read latency and a bench-side preload port.
  logic [15:0] ram [0:FBW-1];
  logic        ram_init, tb_we;
  int          tb_wa;
  logic [15:0] tb_wd;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < FBW; i++) ram[i] <= init_val(i);
    end else begin
      if (tb_we) ram[tb_wa] <= tb_wd;
      else if (mem_clken && mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
      if (mem_clken) mem_readdata <= ram[mem_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Access monitor, sampled mid-cycle.
  int          wa_q[$], wc_q[$], ra_q[$], done_q[$], err_q[$];
  logic [15:0] wd_q[$];
  int          cs_cnt = 0, stall_viol = 0;
  always @(negedge clk) begin
    if (mem_chipselect) cs_cnt <= cs_cnt + 1;
    if (mem_chipselect && !mem_grant) stall_viol <= stall_viol + 1;
    if (mem_chipselect && mem_write) begin
      wa_q.push_back(int'(mem_address));
      wd_q.push_back(mem_writedata);
      wc_q.push_back(cyc);
    end
    if (mem_chipselect && !mem_write) ra_q.push_back(int'(mem_address));
    if (done) done_q.push_back(cyc);
    if (err) err_q.push_back(cyc);
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model: image of the framebuffer plus the expected write stream.
  logic [15:0] mdl [0:FBW-1];
  int          ea_q[$];
  logic [15:0] ed_q[$];

  function automatic bit out_of_range(input bit op, input int x, y, sx, sy);
    return (x + C > W) || (y + C > H) || (op && ((sx + C > W) || (sy + C > H)));
  endfunction

  task automatic model_run(input bit op, input int x, y, sx, sy, input logic [15:0] col,
                           input int npix);
    ea_q.delete();
    ed_q.delete();
    for (int p = 0; p < npix; p++) begin
      int r, c, da, sa;
      logic [15:0] d;
      r  = p / C;
      c  = p % C;
      da = (y + r) * W + x + c;
      sa = (sy + r) * W + sx + c;
      d  = op ? mdl[sa] : col;
      mdl[da] = d;
      ea_q.push_back(da);
      ed_q.push_back(d);
    end
  endtask

  task automatic compare_writes(input string nm, input int base, input int n_obs);
    int nmis = 0;
    check({nm, "_nwr"}, n_obs, ea_q.size());
    for (int i = 0; i < ea_q.size() && i < n_obs; i++)
      if (wa_q[base+i] !== ea_q[i] || wd_q[base+i] !== ed_q[i]) nmis++;
    check({nm, "_wrstream_bad"}, nmis, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input bit op, input int x, y, sx, sy, input logic [15:0] col);
    cmd_op    = op;
    cmd_x     = 9'(x);
    cmd_y     = 8'(y);
    cmd_src_x = 9'(sx);
    cmd_src_y = 8'(sy);
    cmd_color = col;
  endtask

  task automatic issue(input bit op, input int x, y, sx, sy, input logic [15:0] col,
                       output int acc);
    int n = 0;
    while (!cmd_ready && n < 1000) begin step(); n++; end
    if (n >= 1000) check("ready_timeout", 0, 1);
    set_cmd(op, x, y, sx, sy, col);
    cmd_valid = 1'b1;
    acc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int budget);
    int n = 0;
    while (done_q.size() == d0 && err_q.size() == e0 && n < budget) begin step(); n++; end
    if (n >= budget) check("end_timeout", 0, 1);
  endtask

  task automatic run_cmd(input string nm, input bit op, input int x, y, sx, sy,
                         input logic [15:0] col, input bit exp_err);
    int w0, d0, e0, c0, s0, acc;
    w0 = wa_q.size(); d0 = done_q.size(); e0 = err_q.size(); c0 = cs_cnt; s0 = stall_viol;
    issue(op, x, y, sx, sy, col, acc);
    wait_end(d0, e0, 3000);
    step();
    check({nm, "_err_pulses"}, err_q.size() - e0, int'(exp_err));
    if (exp_err) begin
      if (err_q.size() > e0) check({nm, "_err_cycle"}, err_q[e0] - acc, 1);
      check({nm, "_cs_cycles"}, cs_cnt - c0, 0);
      check({nm, "_done_pulses"}, done_q.size() - d0, 0);
      check({nm, "_ready"}, int'(cmd_ready), 1);
    end else begin
      model_run(op, x, y, sx, sy, col, NPIX);
      compare_writes(nm, w0, wa_q.size() - w0);
      check({nm, "_done_pulses"}, done_q.size() - d0, 1);
      check({nm, "_stall_cs"}, stall_viol - s0, 0);
      if (!rand_mode && done_q.size() > d0) begin
        check({nm, "_latency"}, done_q[d0] - acc, op ? 2 * NPIX + 1 : NPIX + 1);
        check({nm, "_cs_cycles"}, cs_cnt - c0, op ? 2 * NPIX : NPIX);
        if (!op && wc_q.size() > w0) check({nm, "_first_wr"}, wc_q[w0] - acc, 1);
      end
    end
  endtask

  typedef struct {
    bit          op;
    int          x, y, sx, sy;
    logic [15:0] col;
    bit          exp_err;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int acc, w0, d0, e0, c0, s0, r0, n;
    bit op;
    int x, y, sx, sy;

    tbl[0] = '{1'b0, 0,   0,   0,   0,   16'hF800, 1'b0};
    tbl[1] = '{1'b0, 315, 0,   0,   0,   16'h1111, 1'b1};
    tbl[2] = '{1'b0, 0,   235, 0,   0,   16'h2222, 1'b1};
    tbl[3] = '{1'b1, 0,   0,   0,   231, 16'h0000, 1'b1};
    tbl[4] = '{1'b0, 310, 230, 0,   0,   16'h07E0, 1'b0};
    tbl[5] = '{1'b1, 100, 50,  310, 230, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 311, 0,   0,   0,   16'h3333, 1'b1};
    tbl[7] = '{1'b1, 300, 0,   0,   0,   16'h0000, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; man_grant = 1'b1; rand_mode = 1'b0;
    tb_we = 1'b0; tb_wa = 0; tb_wd = '0; ram_init = 1'b1;
    set_cmd(1'b0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < FBW; i++) mdl[i] = init_val(i);
    repeat (3) step();
    ram_init = 1'b0;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_cs", int'(mem_chipselect), 0);
    check("rst_write", int'(mem_write), 0);
    check("rst_addr", int'(mem_address), 0);
    check("rst_wdata", int'(mem_writedata), 0);
    check("const_be", int'(mem_byteenable), 3);
    check("const_clken", int'(mem_clken), 1);
    reset = 1'b0;
    step();

    // Table vectors: FILL/COPY at corners and just past the edges.
    for (int i = 0; i < 8; i++)
      run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].sx, tbl[i].sy,
              tbl[i].col, tbl[i].exp_err);
    check("tbl0_last_addr", wa_q[NPIX-1], 2889);

    // Preloaded pattern copied from (0,0) to (10,20).
    for (int r = 0; r < C; r++)
      for (int c = 0; c < C; c++) begin
        tb_we = 1'b1; tb_wa = r * W + c; tb_wd = 16'(r * 16 + c);
        mdl[r * W + c] = 16'(r * 16 + c);
        step();
      end
    tb_we = 1'b0;
    w0 = wa_q.size();
    run_cmd("copy_pat", 1'b1, 10, 20, 0, 0, 16'h0, 1'b0);
    check("copy_pat_a0", wa_q[w0], 6410);
    check("copy_pat_d0", int'(wd_q[w0]), 0);
    check("copy_pat_alast", wa_q[w0+NPIX-1], 9299);
    check("copy_pat_dlast", int'(wd_q[w0+NPIX-1]), 153);

    // FILL with a 7-cycle grant stall before pixel 37.
    w0 = wa_q.size(); d0 = done_q.size(); c0 = cs_cnt; s0 = stall_viol;
    issue(1'b0, 5, 5, 0, 0, 16'h1234, acc);
    n = 0;
    while (wa_q.size() - w0 < 37 && n < 500) begin step(); n++; end
    man_grant = 1'b0;
    repeat (7) step();
    man_grant = 1'b1;
    wait_end(d0, err_q.size(), 1000);
    step();
    model_run(1'b0, 5, 5, 0, 0, 16'h1234, NPIX);
    compare_writes("fill_stall", w0, wa_q.size() - w0);
    check("fill_stall_cs", cs_cnt - c0, NPIX);
    check("fill_stall_viol", stall_viol - s0, 0);
    check("fill_stall_gap", wc_q[w0+37] - wc_q[w0+36], 8);
    if (done_q.size() > d0) check("fill_stall_latency", done_q[d0] - acc, NPIX + 8);

    // COPY with grant dropped during the write of pixel 50.
    w0 = wa_q.size(); d0 = done_q.size(); c0 = cs_cnt; r0 = ra_q.size();
    issue(1'b1, 200, 150, 40, 100, 16'h0, acc);
    n = 0;
    while (ra_q.size() - r0 < 51 && n < 500) begin step(); n++; end
    man_grant = 1'b0;
    step();
    man_grant = 1'b1;
    wait_end(d0, err_q.size(), 1000);
    step();
    model_run(1'b1, 200, 150, 40, 100, 16'h0, NPIX);
    compare_writes("copy_stall", w0, wa_q.size() - w0);
    check("copy_stall_reads", ra_q.size() - r0, NPIX + 1);
    check("copy_stall_reread_a", ra_q[r0+50], 33640);
    check("copy_stall_reread_b", ra_q[r0+51], 33640);
    check("copy_stall_cs", cs_cnt - c0, 2 * NPIX + 1);
    if (done_q.size() > d0) check("copy_stall_latency", done_q[d0] - acc, 2 * NPIX + 3);

    // Reset during a COPY at pixel 20.
    w0 = wa_q.size(); d0 = done_q.size();
    issue(1'b1, 150, 60, 100, 100, 16'h0, acc);
    n = 0;
    while (wa_q.size() - w0 < 20 && n < 500) begin step(); n++; end
    reset = 1'b1;
    step();
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_ready", int'(cmd_ready), 1);
    check("rstmid_cs", int'(mem_chipselect), 0);
    reset = 1'b0;
    c0 = cs_cnt;
    repeat (5) step();
    check("rstmid_idle_cs", cs_cnt - c0, 0);
    check("rstmid_done", done_q.size() - d0, 0);
    model_run(1'b1, 150, 60, 100, 100, 16'h0, 20);
    compare_writes("rstmid", w0, wa_q.size() - w0);

    // Back-to-back FILLs with cmd_valid held.
    w0 = wa_q.size(); d0 = done_q.size();
    set_cmd(1'b0, 20, 40, 0, 0, 16'hAAAA);
    cmd_valid = 1'b1;
    step();
    set_cmd(1'b0, 40, 40, 0, 0, 16'h5555);
    n = 0;
    while (done_q.size() == d0 && n < 500) begin step(); n++; end
    cmd_valid = 1'b0;
    wait_end(d0 + 1, err_q.size(), 1000);
    step();
    check("b2b_nwr", wa_q.size() - w0, 2 * NPIX);
    model_run(1'b0, 20, 40, 0, 0, 16'hAAAA, NPIX);
    compare_writes("b2b_a", w0, NPIX);
    model_run(1'b0, 40, 40, 0, 0, 16'h5555, NPIX);
    compare_writes("b2b_b", w0 + NPIX, wa_q.size() - w0 - NPIX);
    if (done_q.size() > d0 && wc_q.size() > w0 + NPIX)
      check("b2b_accept_in_done", wc_q[w0+NPIX] - done_q[d0], 1);

    // Random commands under a random grant pattern.
    rand_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      op = 1'($urandom_range(1));
      x  = ($urandom_range(3) == 0) ? $urandom_range(300, 319) : $urandom_range(0, 310);
      y  = ($urandom_range(3) == 0) ? $urandom_range(220, 239) : $urandom_range(0, 230);
      sx = ($urandom_range(5) == 0) ? $urandom_range(300, 319) : $urandom_range(0, 310);
      sy = ($urandom_range(5) == 0) ? $urandom_range(220, 239) : $urandom_range(0, 230);
      run_cmd($sformatf("rnd%0d", k), op, x, y, sx, sy, 16'($urandom),
              out_of_range(op, x, y, sx, sy));
    end
    rand_mode = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
